// File: rtl/poly_key_freq_pkg.sv
// Shared widths, the voice action type and helpers for the polyphonic key-to-frequency mapper.
package poly_key_freq_pkg;

    localparam int unsigned DefNumVoices = 4;
    localparam int unsigned DefCodeW     = 8;
    localparam int unsigned DefFreqW     = 16;
    localparam int unsigned DefTimeoutW  = 25;

    // A hold counter at all-ones means the voice has expired.
    localparam logic [DefTimeoutW-1:0] DefCntMax = '1;

    // What the S2 event does to its target voice.
    typedef enum logic [1:0] {
        ActNone,
        ActRefresh,
        ActLoad,
        ActRelease
    } voice_act_e;

    // Bit offset of voice v inside the packed freq output bus.
    function automatic int unsigned freq_lsb(input int unsigned voice, input int unsigned freq_w);
        return voice * freq_w;
    endfunction

    // Contents of keyfreq.mif: PS/2 set-2 make codes of the home row mapped to tone words.
    // Every code not listed reads as 0, which marks the key as unmapped.
    function automatic logic [31:0] builtin_freq(input logic [31:0] code);
        case (code)
            32'h1C:  return 32'h0106;
            32'h1B:  return 32'h0115;
            32'h23:  return 32'h0126;
            32'h2B:  return 32'h0137;
            32'h34:  return 32'h0149;
            32'h33:  return 32'h015D;
            32'h3B:  return 32'h0172;
            32'h42:  return 32'h0188;
            32'h4B:  return 32'h01A0;
            default: return 32'h0000;
        endcase
    endfunction

endpackage

// File: rtl/key_freq_rom.sv
// Synchronous-read key-code to frequency ROM, one cycle of read latency.
module key_freq_rom
    import poly_key_freq_pkg::*;
#(
    parameter int unsigned CODE_W     = DefCodeW,
    parameter int unsigned FREQ_W     = DefFreqW,
    parameter string       TABLE_FILE = "keyfreq.mif"
) (
    input  logic              clk,
    input  logic [CODE_W-1:0] addr,
    output logic [FREQ_W-1:0] rd_data
);

    // Table data is compiled in so no file is needed at elaboration; an empty
    // TABLE_FILE name selects an all-zero table (every key unmapped).
    localparam bit TableLoaded = (TABLE_FILE != "");

    logic [FREQ_W-1:0] rd_data_q;

    // Registered read: data lines up with the S1 event registers.
    always_ff @(posedge clk) begin
        rd_data_q <= TableLoaded ? FREQ_W'(builtin_freq(32'(addr))) : '0;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/poly_key_freq.sv
// Polyphonic key-to-frequency mapper: ROM lookup, voice allocation/stealing, per-voice hold timeout.
module poly_key_freq
    import poly_key_freq_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DefNumVoices,
    parameter int unsigned CODE_W     = DefCodeW,
    parameter int unsigned FREQ_W     = DefFreqW,
    parameter int unsigned TIMEOUT_W  = DefTimeoutW,
    parameter string       TABLE_FILE = "keyfreq.mif"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [CODE_W-1:0]            key_code,
    input  logic                         key_release,
    output logic [NUM_VOICES*FREQ_W-1:0] freq,
    output logic [NUM_VOICES-1:0]        voice_restart,
    output logic [NUM_VOICES-1:0]        voice_busy
);

    localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [TIMEOUT_W-1:0] CntMax  = '1;
    // Expiry is taken on the edge that moves the counter onto all-ones.
    localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(CntMax - 1'b1);

    // S1 event registers
    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic              s1_release_q;
    logic [FREQ_W-1:0] rom_data;

    // Per-voice state
    logic [CODE_W-1:0]    code_q [NUM_VOICES];
    logic [CODE_W-1:0]    code_d [NUM_VOICES];
    logic [FREQ_W-1:0]    freq_q [NUM_VOICES];
    logic [FREQ_W-1:0]    freq_d [NUM_VOICES];
    logic [TIMEOUT_W-1:0] cnt_q  [NUM_VOICES];
    logic [TIMEOUT_W-1:0] cnt_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy_q, busy_d;
    logic [NUM_VOICES-1:0] restart_q, restart_d;

    // Allocation search results
    logic                 match_found;
    logic [IdxW-1:0]      match_idx;
    logic                 free_found;
    logic [IdxW-1:0]      free_idx;
    logic [IdxW-1:0]      oldest_idx;
    logic [TIMEOUT_W-1:0] oldest_cnt;

    voice_act_e      act;
    logic [IdxW-1:0] target;

    key_freq_rom #(
        .CODE_W     (CODE_W),
        .FREQ_W     (FREQ_W),
        .TABLE_FILE (TABLE_FILE)
    ) u_rom (
        .clk     (clk),
        .addr    (key_code),
        .rd_data (rom_data)
    );

    // S1: capture the event alongside the ROM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_release_q <= 1'b0;
        end else begin
            s1_valid_q   <= key_valid;
            s1_code_q    <= key_code;
            s1_release_q <= key_release;
        end
    end

    // Search registered voice state: held-key match, lowest free voice, oldest voice.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        oldest_idx  = '0;
        oldest_cnt  = cnt_q[0];
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (busy_q[v] && (code_q[v] == s1_code_q) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IdxW'(v);
            end
            if (!busy_q[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(v);
            end
            // Strict compare keeps ties on the lowest index.
            if (cnt_q[v] > oldest_cnt) begin
                oldest_cnt = cnt_q[v];
                oldest_idx = IdxW'(v);
            end
        end
    end

    // S2: decide what the event does and which voice it targets.
    always_comb begin
        act    = ActNone;
        target = '0;
        if (s1_valid_q && (s1_code_q != '0)) begin
            if (s1_release_q) begin
                if (match_found) begin
                    act    = ActRelease;
                    target = match_idx;
                end
            end else if (match_found) begin
                act    = ActRefresh;
                target = match_idx;
            end else if (rom_data != '0) begin
                act    = ActLoad;
                target = free_found ? free_idx : oldest_idx;
            end
        end
    end

    // Per-voice next state: timeout first, then the S2 event overrides its target.
    always_comb begin
        busy_d    = busy_q;
        restart_d = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            code_d[v] = code_q[v];
            freq_d[v] = freq_q[v];
            cnt_d[v]  = cnt_q[v];
        end
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (busy_q[v]) begin
                if (cnt_q[v] == CntLast) begin
                    cnt_d[v]     = CntMax;
                    freq_d[v]    = '0;
                    busy_d[v]    = 1'b0;
                    restart_d[v] = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + 1'b1;
                end
            end
            if ((act != ActNone) && (target == IdxW'(v))) begin
                unique case (act)
                    ActRefresh: begin
                        cnt_d[v]     = '0;
                        freq_d[v]    = freq_q[v];
                        busy_d[v]    = 1'b1;
                        restart_d[v] = 1'b0;
                    end
                    ActLoad: begin
                        code_d[v]    = s1_code_q;
                        freq_d[v]    = rom_data;
                        cnt_d[v]     = '0;
                        busy_d[v]    = 1'b1;
                        restart_d[v] = 1'b1;
                    end
                    ActRelease: begin
                        freq_d[v]    = '0;
                        cnt_d[v]     = '0;
                        busy_d[v]    = 1'b0;
                        restart_d[v] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Voice state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            restart_q <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                code_q[v] <= '0;
                freq_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            restart_q <= restart_d;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                code_q[v] <= code_d[v];
                freq_q[v] <= freq_d[v];
                cnt_q[v]  <= cnt_d[v];
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_freq
        assign freq[freq_lsb(v, FREQ_W) +: FREQ_W] = freq_q[v];
    end

    assign voice_restart = restart_q;
    assign voice_busy    = busy_q;

endmodule

// File: tb/tb_poly_key_freq.sv
// Scoreboard bench for poly_key_freq: rows drive events and push expected outputs, compared when due.
module tb_poly_key_freq;

    localparam int unsigned NV = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = 16;

    localparam logic [15:0] T1C = 16'h0106;
    localparam logic [15:0] T1B = 16'h0115;
    localparam logic [15:0] T23 = 16'h0126;
    localparam logic [15:0] T2B = 16'h0137;
    localparam logic [15:0] T34 = 16'h0149;

    // Row kinds: 0 check only, 1 drive + expect at +2, 2 drive only, 3 assert reset + expect now
    typedef struct {
        int          t;
        int          kind;
        logic [7:0]  code;
        bit          rel;
        logic [63:0] f;
        logic [3:0]  r;
        logic [3:0]  b;
        string       name;
    } row_t;

    typedef struct {
        int          cyc;
        logic [63:0] f;
        logic [3:0]  r;
        logic [3:0]  b;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              key_valid = 1'b0;
    logic [CW-1:0]     key_code = '0;
    logic              key_release = 1'b0;
    logic [NV*FW-1:0]  freq;
    logic [NV-1:0]     voice_restart;
    logic [NV-1:0]     voice_busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t0 = 0;
    row_t rows[$];
    exp_t sb[$];

    poly_key_freq #(
        .NUM_VOICES (NV),
        .CODE_W     (CW),
        .FREQ_W     (FW),
        .TIMEOUT_W  (6),
        .TABLE_FILE ("keyfreq.mif")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_release   (key_release),
        .freq          (freq),
        .voice_restart (voice_restart),
        .voice_busy    (voice_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(input logic [15:0] f3, input logic [15:0] f2,
                                       input logic [15:0] f1, input logic [15:0] f0);
        return {f3, f2, f1, f0};
    endfunction

    function automatic void add_row(input int t, input int kind, input logic [7:0] code,
                                    input bit rel, input logic [63:0] f, input logic [3:0] r,
                                    input logic [3:0] b, input string name);
        row_t x;
        x.t = t; x.kind = kind; x.code = code; x.rel = rel;
        x.f = f; x.r = r; x.b = b; x.name = name;
        rows.push_back(x);
    endfunction

    // Apply every row scheduled for relative cycle k; called just after a rising edge.
    task automatic issue_rows(input int k);
        exp_t e;
        while (rows.size() > 0 && rows[0].t == k) begin
            e.f = rows[0].f; e.r = rows[0].r; e.b = rows[0].b; e.name = rows[0].name;
            e.cyc = cyc;
            if (rows[0].kind == 1 || rows[0].kind == 2) begin
                key_valid   = 1'b1;
                key_code    = rows[0].code;
                key_release = rows[0].rel;
            end
            if (rows[0].kind == 1) e.cyc = cyc + 2;
            if (rows[0].kind == 3) reset = 1'b1;
            if (rows[0].kind != 2) sb.push_back(e);
            void'(rows.pop_front());
        end
    endtask

    task automatic apply_reset();
        key_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int t = 0; t < 3; t++) add_row(t, 0, 8'h00, 0, '0, 4'b0000, 4'b0000, "reset_state");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL reset_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_single();
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "single_press");
        for (int t = 3; t <= 64; t++)
            add_row(t, 0, 8'h00, 0, pk(0, 0, 0, T1C), 4'b0000, 4'b0001, "single_hold");
        add_row(65, 0, 8'h00, 0, '0, 4'b0001, 4'b0000, "single_timeout");
        add_row(66, 0, 8'h00, 0, '0, 4'b0000, 4'b0000, "single_after");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL single_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_poly_release();
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "poly_v0");
        add_row(1, 1, 8'h1B, 0, pk(0, 0, T1B, T1C), 4'b0010, 4'b0011, "poly_v1");
        add_row(2, 1, 8'h23, 0, pk(0, T23, T1B, T1C), 4'b0100, 4'b0111, "poly_v2");
        add_row(5, 1, 8'h1B, 1, pk(0, T23, 0, T1C), 4'b0010, 4'b0101, "poly_release");
        add_row(6, 0, 8'h00, 0, pk(0, T23, T1B, T1C), 4'b0000, 4'b0111, "poly_quiet");
        add_row(8, 0, 8'h00, 0, pk(0, T23, 0, T1C), 4'b0000, 4'b0101, "poly_after");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL poly_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "b2b_make");
        add_row(1, 1, 8'h1C, 1, '0, 4'b0001, 4'b0000, "b2b_release");
        add_row(2, 1, 8'h1B, 0, pk(0, 0, 0, T1B), 4'b0001, 4'b0001, "b2b_realloc");
        add_row(5, 0, 8'h00, 0, pk(0, 0, 0, T1B), 4'b0000, 4'b0001, "b2b_quiet");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL b2b_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_refresh();
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "refresh_first");
        add_row(40, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0000, 4'b0001, "refresh_repeat");
        add_row(41, 0, 8'h00, 0, pk(0, 0, 0, T1C), 4'b0000, 4'b0001, "refresh_pre");
        add_row(65, 0, 8'h00, 0, pk(0, 0, 0, T1C), 4'b0000, 4'b0001, "refresh_old_deadline");
        add_row(104, 0, 8'h00, 0, pk(0, 0, 0, T1C), 4'b0000, 4'b0001, "refresh_hold");
        add_row(105, 0, 8'h00, 0, '0, 4'b0001, 4'b0000, "refresh_timeout");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL refresh_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_steal();
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "steal_fill0");
        add_row(10, 1, 8'h1B, 0, pk(0, 0, T1B, T1C), 4'b0010, 4'b0011, "steal_fill1");
        add_row(20, 1, 8'h23, 0, pk(0, T23, T1B, T1C), 4'b0100, 4'b0111, "steal_fill2");
        add_row(30, 1, 8'h2B, 0, pk(T2B, T23, T1B, T1C), 4'b1000, 4'b1111, "steal_fill3");
        add_row(40, 1, 8'h34, 0, pk(T2B, T23, T1B, T34), 4'b0001, 4'b1111, "steal_oldest");
        add_row(43, 0, 8'h00, 0, pk(T2B, T23, T1B, T34), 4'b0000, 4'b1111, "steal_quiet");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL steal_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_ignored_conflict();
        logic [63:0] full;
        full = pk(T2B, T23, T1B, T1C);
        apply_reset();
        add_row(0, 1, 8'h1C, 0, pk(0, 0, 0, T1C), 4'b0001, 4'b0001, "ign_fill0");
        add_row(1, 1, 8'h1B, 0, pk(0, 0, T1B, T1C), 4'b0010, 4'b0011, "ign_fill1");
        add_row(2, 1, 8'h23, 0, pk(0, T23, T1B, T1C), 4'b0100, 4'b0111, "ign_fill2");
        add_row(3, 1, 8'h2B, 0, full, 4'b1000, 4'b1111, "ign_fill3");
        add_row(10, 1, 8'h00, 0, full, 4'b0000, 4'b1111, "ign_code0");
        add_row(11, 1, 8'h15, 0, full, 4'b0000, 4'b1111, "ign_zero_entry");
        add_row(12, 1, 8'h33, 1, full, 4'b0000, 4'b1111, "ign_unheld_release");
        add_row(63, 1, 8'h34, 0, pk(T2B, T23, T1B, T34), 4'b0001, 4'b1111, "conflict_steal");
        add_row(64, 0, 8'h00, 0, full, 4'b0000, 4'b1111, "conflict_pre");
        add_row(66, 0, 8'h00, 0, pk(T2B, T23, 0, T34), 4'b0010, 4'b1101, "conflict_next_timeout");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL ignored_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        add_row(0, 1, 8'h1B, 0, pk(0, 0, 0, T1B), 4'b0001, 4'b0001, "areset_setup");
        add_row(3, 0, 8'h00, 0, pk(0, 0, 0, T1B), 4'b0000, 4'b0001, "areset_held");
        add_row(4, 2, 8'h1C, 0, '0, 4'b0000, 4'b0000, "areset_event");
        add_row(5, 3, 8'h00, 0, '0, 4'b0000, 4'b0000, "areset_immediate");
        for (int t = 6; t < 10; t++)
            add_row(t, 0, 8'h00, 0, '0, 4'b0000, 4'b0000, "areset_dropped");
        t0 = cyc;
        for (int k = 0; k < 300 && (rows.size() > 0 || sb.size() > 0); k++) begin
            issue_rows(k);
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_cmp++;
                    if (sb[i].cyc != cyc || freq !== sb[i].f || voice_restart !== sb[i].r ||
                        voice_busy !== sb[i].b) begin
                        n_err++;
                        $display("FAIL %s t=%0d: freq=%h restart=%b busy=%b, want freq=%h restart=%b busy=%b (due t=%0d)",
                                 sb[i].name, cyc - t0, freq, voice_restart, voice_busy,
                                 sb[i].f, sb[i].r, sb[i].b, sb[i].cyc - t0);
                    end
                    sb.delete(i);
                end
            end
            @(posedge clk); #1;
            key_valid = 1'b0; reset = 1'b0;
        end
        if (rows.size() > 0 || sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL areset_bound: %0d rows / %0d expectations left, want 0", rows.size(), sb.size());
            rows.delete(); sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_poly_release();
        test_back_to_back();
        test_refresh();
        test_steal();
        test_ignored_conflict();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
